// File: rtl/calc_key_sequencer.sv
// Keypad front-end for the calculator datapath: builds BCD operands, starts the datapath on '='
// and latches its result. Define CALC_CHAIN_EN to evaluate on an operator typed after operand 2.
module calc_key_sequencer #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [7:0]              key_code,
  input  logic                    calc_done,
  input  logic [11:0]             calc_result,
  output logic [4*MAX_DIGITS-1:0] reg_num1,
  output logic [4*MAX_DIGITS-1:0] reg_num2,
  output logic [2:0]              cnt1,
  output logic [2:0]              cnt2,
  output logic [7:0]              sym,
  output logic                    calc_start,
  output logic [11:0]             disp_bcd,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned W  = 4 * MAX_DIGITS;
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0]    CntMax  = 3'(MAX_DIGITS);
  localparam logic [TW-1:0] TmrLast = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StEnter1, StEnter2, StCalc, StWait, StShow} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  num1_q, num1_d, num2_q, num2_d;
  logic [2:0]    cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [7:0]    sym_q, sym_d;
  logic [11:0]   disp_q, disp_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          start_q, busy_q;
`ifdef CALC_CHAIN_EN
  logic [7:0]    pend_q, pend_d;
`endif

  logic key_dig, key_op, key_eq, key_clr, div_zero;

  assign key_dig  = key_valid && (key_code[7:4] == 4'h3) && (key_code[3:0] <= 4'h9);
  assign key_op   = key_valid && (key_code >= 8'h61) && (key_code <= 8'h64);
  assign key_eq   = key_valid && (key_code == 8'h65);
  assign key_clr  = key_valid && (key_code == 8'h66);
  assign div_zero = (sym_q == 8'h64) && (num2_q == '0);

  // Resize a 3-digit BCD value to operand width (zero-extend or keep the low digits).
  function automatic logic [W-1:0] to_operand(input logic [11:0] bcd);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MAX_DIGITS) && i < 3; i++) r[4*i +: 4] = bcd[4*i +: 4];
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    sym_d   = sym_q;
    disp_d  = disp_q;
    err_d   = err_q;
    tmr_d   = tmr_q;
`ifdef CALC_CHAIN_EN
    pend_d  = pend_q;
`endif
    if (key_clr) begin
      state_d = StEnter1;
      num1_d  = '0;
      num2_d  = '0;
      cnt1_d  = '0;
      cnt2_d  = '0;
      sym_d   = '0;
      disp_d  = '0;
      err_d   = 1'b0;
`ifdef CALC_CHAIN_EN
      pend_d  = '0;
`endif
    end else begin
      unique case (state_q)
        StEnter1: begin
          if (key_dig) begin
            if (cnt1_q == CntMax) err_d = 1'b1;
            else begin
              num1_d = {num1_q[W-5:0], key_code[3:0]};
              cnt1_d = cnt1_q + 3'd1;
            end
          end else if (key_op) begin
            sym_d   = key_code;
            state_d = StEnter2;
          end
        end
        StEnter2: begin
          if (key_dig) begin
            if (cnt2_q == CntMax) err_d = 1'b1;
            else begin
              num2_d = {num2_q[W-5:0], key_code[3:0]};
              cnt2_d = cnt2_q + 3'd1;
            end
          end else if (key_op && (cnt2_q == '0)) begin
            sym_d = key_code;
`ifdef CALC_CHAIN_EN
          end else if (key_op) begin
            // Chained operator: evaluate now, then continue with the result as operand 1.
            if (div_zero) begin
              err_d   = 1'b1;
              num1_d  = to_operand(disp_q);
              cnt1_d  = CntMax;
              num2_d  = '0;
              cnt2_d  = '0;
              sym_d   = key_code;
            end else begin
              pend_d  = key_code;
              state_d = StCalc;
            end
`endif
          end else if (key_eq) begin
            if (div_zero) begin
              err_d   = 1'b1;
              state_d = StShow;
            end else begin
              state_d = StCalc;
`ifdef CALC_CHAIN_EN
              pend_d  = '0;
`endif
            end
          end
        end
        StCalc: begin
          state_d = StWait;
          tmr_d   = '0;
        end
        StWait: begin
          if (calc_done) begin
            disp_d  = calc_result;
            state_d = StShow;
`ifdef CALC_CHAIN_EN
            if (pend_q != '0) begin
              num1_d  = to_operand(calc_result);
              cnt1_d  = CntMax;
              num2_d  = '0;
              cnt2_d  = '0;
              sym_d   = pend_q;
              pend_d  = '0;
              state_d = StEnter2;
            end
`endif
          end else if (tmr_q == TmrLast) begin
            err_d   = 1'b1;
            state_d = StShow;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        StShow: begin
          if (key_dig) begin
            num1_d      = '0;
            num1_d[3:0] = key_code[3:0];
            cnt1_d      = 3'd1;
            num2_d      = '0;
            cnt2_d      = '0;
            sym_d       = '0;
            state_d     = StEnter1;
          end else if (key_op) begin
            num1_d  = to_operand(disp_q);
            cnt1_d  = CntMax;
            num2_d  = '0;
            cnt2_d  = '0;
            sym_d   = key_code;
            state_d = StEnter2;
          end
        end
        default: state_d = StEnter1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEnter1;
      num1_q  <= '0;
      num2_q  <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      sym_q   <= '0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CALC_CHAIN_EN
      pend_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      sym_q   <= sym_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      start_q <= (state_d == StCalc);
      busy_q  <= (state_d == StCalc) || (state_d == StWait);
`ifdef CALC_CHAIN_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign reg_num1   = num1_q;
  assign reg_num2   = num2_q;
  assign cnt1       = cnt1_q;
  assign cnt2       = cnt2_q;
  assign sym        = sym_q;
  assign disp_bcd   = disp_q;
  assign err        = err_q;
  assign calc_start = start_q;
  assign busy       = busy_q;

endmodule
